// File: rtl/next_tx_arbiter.sv
// next_tx_arbiter: shares the single 40-bit NeXT serial transmit path among
// four packet requesters (0 keyboard, 1 mouse, 2 sound, 3 control).
// Round-robin arbitration issues one packet per credit. The credit returns
// SLOT_DELAY cycles after a frame_tick, which keeps the sender's one-deep
// buffer from being overwritten.
//
// Handshake: a requester holds req_valid[i] high with stable data until it
// sees a one-cycle req_ready[i] pulse. The arbiter drives out_valid as a
// single-cycle registered strobe with out_data stable. The sender answers
// combinationally on out_retrieved in that same cycle. req_ready pulses in
// the out_valid cycle only when out_retrieved is high. A dropped packet
// (out_retrieved low) sets err_reject and is retried at the next credit.
// fsm_state exposes the controller state: 0 READY, 1 ISSUE, 2 WAIT_SLOT.
module next_tx_arbiter #(
  parameter int SLOT_DELAY   = 48,
  parameter bit PRIO0_URGENT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req_valid,
  input  logic [159:0] req_data,
  output logic [3:0]   req_ready,
  input  logic         frame_tick,
  output logic [39:0]  out_data,
  output logic         out_valid,
  input  logic         out_retrieved,
  output logic [1:0]   grant_id,
  output logic [15:0]  pkt_count,
  output logic         err_reject,
  input  logic         err_clear,
  output logic [1:0]   fsm_state
);

  localparam int CW = $clog2(SLOT_DELAY + 1);

  typedef enum logic [1:0] {
    READY     = 2'd0,
    ISSUE     = 2'd1,
    WAIT_SLOT = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    last_grant;
  logic          retry_pending;
  logic [CW-1:0] slot_cnt;

  logic [39:0]   slot_data [4];
  logic          rr_found;
  logic [1:0]    rr_id;
  logic          pick_valid;
  logic [1:0]    pick_id;

  assign fsm_state = state;

  // Split the flat request bus into one 40-bit packet per requester.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      slot_data[i] = req_data[40*i +: 40];
    end
  end

  // Round-robin search: the first valid requester after last_grant, wrapping 3->0.
  always_comb begin
    rr_found = 1'b0;
    rr_id    = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      if (!rr_found && req_valid[last_grant + 2'(k)]) begin
        rr_found = 1'b1;
        rr_id    = last_grant + 2'(k);
      end
    end
  end

  // Winner selection: a pending retry comes first, then the urgent requester 0, then round-robin.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = 2'd0;
    if (retry_pending && req_valid[grant_id]) begin
      pick_valid = 1'b1;
      pick_id    = grant_id;
    end else if (PRIO0_URGENT && req_valid[0]) begin
      pick_valid = 1'b1;
      pick_id    = 2'd0;
    end else if (rr_found) begin
      pick_valid = 1'b1;
      pick_id    = rr_id;
    end
  end

  // Accept pulse goes to the granted requester in the strobe cycle, and only when the sender takes the packet.
  always_comb begin
    req_ready = 4'b0000;
    if (state == ISSUE && out_retrieved) begin
      req_ready = 4'b0001 << grant_id;
    end
  end

  // Controller: credit, issue strobe, slot pacing, counters and the sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= READY;
      out_valid     <= 1'b0;
      out_data      <= '0;
      grant_id      <= 2'd0;
      last_grant    <= 2'd3;
      pkt_count     <= 16'd0;
      err_reject    <= 1'b0;
      retry_pending <= 1'b0;
      slot_cnt      <= '0;
    end else begin
      out_valid <= 1'b0;

      // A clear wins over a reject in the same cycle.
      if (err_clear) begin
        err_reject <= 1'b0;
      end else if (state == ISSUE && !out_retrieved) begin
        err_reject <= 1'b1;
      end

      case (state)
        READY: begin
          // The retried requester gave up its packet, so fall back to normal arbitration.
          if (retry_pending && !req_valid[grant_id]) begin
            retry_pending <= 1'b0;
          end
          if (pick_valid) begin
            out_data  <= slot_data[pick_id];
            grant_id  <= pick_id;
            out_valid <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (out_retrieved) begin
            last_grant    <= grant_id;
            pkt_count     <= pkt_count + 16'd1;
            retry_pending <= 1'b0;
          end else begin
            retry_pending <= 1'b1;
          end
          slot_cnt <= '0;
          state    <= WAIT_SLOT;
        end
        WAIT_SLOT: begin
          // A tick (re)starts the countdown; the credit returns SLOT_DELAY cycles after the latest tick.
          if (frame_tick) begin
            slot_cnt <= CW'(SLOT_DELAY);
          end else if (slot_cnt == CW'(1)) begin
            slot_cnt <= '0;
            state    <= READY;
          end else if (slot_cnt != '0) begin
            slot_cnt <= slot_cnt - CW'(1);
          end
        end
        default: begin
          state <= READY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_next_tx_arbiter.sv
// Directed bench for next_tx_arbiter: reset, single grant, round-robin and
// urgent priority, reject/retry, tick restart and packet counter wrap.
module tb_next_tx_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [39:0]  d [4];
  logic [159:0] req_data;
  logic         frame_tick;
  logic         err_clear;
  logic         accept_en;

  logic [3:0]   req_ready,  req_ready_u;
  logic [39:0]  out_data,   out_data_u;
  logic         out_valid,  out_valid_u;
  logic         out_retrieved, out_retrieved_u;
  logic [1:0]   grant_id,   grant_id_u;
  logic [15:0]  pkt_count,  pkt_count_u;
  logic         err_reject, err_reject_u;
  logic [1:0]   fsm_state,  fsm_state_u;

  int checks = 0;
  int errors = 0;

  assign req_data        = {d[3], d[2], d[1], d[0]};
  // The sender model: its buffer takes the packet in the strobe cycle when accept_en is high.
  assign out_retrieved   = out_valid & accept_en;
  assign out_retrieved_u = out_valid_u & accept_en;

  next_tx_arbiter #(.SLOT_DELAY(48), .PRIO0_URGENT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .frame_tick(frame_tick), .out_data(out_data),
    .out_valid(out_valid), .out_retrieved(out_retrieved), .grant_id(grant_id),
    .pkt_count(pkt_count), .err_reject(err_reject), .err_clear(err_clear),
    .fsm_state(fsm_state)
  );

  next_tx_arbiter #(.SLOT_DELAY(48), .PRIO0_URGENT(1'b1)) dut_u (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready_u), .frame_tick(frame_tick), .out_data(out_data_u),
    .out_valid(out_valid_u), .out_retrieved(out_retrieved_u), .grant_id(grant_id_u),
    .pkt_count(pkt_count_u), .err_reject(err_reject_u), .err_clear(err_clear),
    .fsm_state(fsm_state_u)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_valid  = 4'b0000;
    frame_tick = 1'b0;
    err_clear  = 1'b0;
    accept_en  = 1'b1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int k);
    k = 0;
    while (!out_valid && k < max) begin
      step();
      k++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'b0000; frame_tick = 1'b0; err_clear = 1'b0; accept_en = 1'b1;
    d[0] = 40'h0; d[1] = 40'h0; d[2] = 40'h0; d[3] = 40'h0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
    checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL reset_pkt_count got %h exp 0", pkt_count); end
    checks++; if (err_reject !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_reject); end
    checks++; if (out_data !== 40'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    checks++; if (grant_id !== 2'd0 || fsm_state !== 2'd0) begin errors++; $display("FAIL reset_grant_state got %0d/%0d exp 0/0", grant_id, fsm_state); end
    @(negedge clk);
    d[1] = 40'h1122334455;
    req_valid = 4'b0010;
    rst_n = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL release_out_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 40'h1122334455) begin errors++; $display("FAIL release_out_data got %h exp 1122334455", out_data); end
    req_valid = 4'b0000;
    step();
    checks++; if (pkt_count !== 16'd1 || fsm_state !== 2'd2) begin errors++; $display("FAIL release_count_state got %0d/%0d exp 1/2", pkt_count, fsm_state); end
    // asynchronous reset from WAIT_SLOT
    rst_n = 1'b0;
    #1;
    checks++; if (pkt_count !== 16'd0 || fsm_state !== 2'd0 || grant_id !== 2'd0) begin errors++; $display("FAIL midreset_wait got cnt %0d st %0d gid %0d exp 0/0/0", pkt_count, fsm_state, grant_id); end
    // asynchronous reset from ISSUE aborts the packet with no ready pulse
    @(negedge clk);
    req_valid = 4'b0001;
    rst_n = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL issue_before_reset got %b exp 1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL midreset_issue got ov %b rdy %b exp 0/0000", out_valid, req_ready); end
    step();
    checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL midreset_count got %0d exp 0", pkt_count); end
  endtask

  task automatic test_single();
    do_reset();
    d[1] = 40'h0A12345678;
    req_valid = 4'b0010;
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 40'h0A12345678) begin errors++; $display("FAIL single_out_data got %h exp 0a12345678", out_data); end
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_req_ready got %b exp 0010", req_ready); end
    req_valid = 4'b0000;
    step();
    checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL single_pkt_count got %0d exp 1", pkt_count); end
    checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL single_grant got %0d exp 1", grant_id); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_strobe_len got %b exp 0", out_valid); end
  endtask

  task automatic test_round_robin();
    int exp_rr [5] = '{0, 1, 2, 3, 0};
    int k;
    logic [1:0] e;
    do_reset();
    d[0] = 40'h00A0A0A0A0; d[1] = 40'h11B1B1B1B1; d[2] = 40'h22C2C2C2C2; d[3] = 40'h33D3D3D3D3;
    req_valid = 4'b1111;
    step();
    for (int g = 0; g < 5; g++) begin
      e = 2'(exp_rr[g]);
      if (g > 0) begin
        tick();
        wait_valid(60, k);
        checks++; if (k !== 49) begin errors++; $display("FAIL rr_slot_latency[%0d] got %0d exp 49", g, k); end
      end
      checks++; if (out_valid !== 1'b1 || grant_id !== e) begin errors++; $display("FAIL rr_grant[%0d] got ov %b gid %0d exp 1/%0d", g, out_valid, grant_id, e); end
      checks++; if (out_data !== d[e]) begin errors++; $display("FAIL rr_data[%0d] got %h exp %h", g, out_data, d[e]); end
      checks++; if (req_ready !== (4'b0001 << e)) begin errors++; $display("FAIL rr_ready[%0d] got %b exp %b", g, req_ready, 4'b0001 << e); end
      checks++; if (out_valid_u !== 1'b1 || grant_id_u !== 2'd0 || req_ready_u !== 4'b0001) begin errors++; $display("FAIL urgent_grant[%0d] got ov %b gid %0d rdy %b exp 1/0/0001", g, out_valid_u, grant_id_u, req_ready_u); end
      step();
      checks++; if (out_valid !== 1'b0 || out_valid_u !== 1'b0) begin errors++; $display("FAIL rr_back_to_back[%0d] got %b/%b exp 0/0", g, out_valid, out_valid_u); end
      for (int i = 0; i < 5; i++) begin
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_no_credit[%0d] got %b exp 0", g, out_valid); end
      end
    end
    checks++; if (pkt_count !== 16'd5 || pkt_count_u !== 16'd5) begin errors++; $display("FAIL rr_count got %0d/%0d exp 5/5", pkt_count, pkt_count_u); end
  endtask

  task automatic test_reject();
    int k;
    do_reset();
    d[0] = 40'h0000000F0F; d[1] = 40'h1111111F1F; d[2] = 40'h2222222222;
    req_valid = 4'b0100;
    accept_en = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1 || grant_id !== 2'd2) begin errors++; $display("FAIL rej_issue got ov %b gid %0d exp 1/2", out_valid, grant_id); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rej_no_ready got %b exp 0000", req_ready); end
    step();
    checks++; if (err_reject !== 1'b1 || pkt_count !== 16'd0) begin errors++; $display("FAIL rej_err got err %b cnt %0d exp 1/0", err_reject, pkt_count); end
    // retry must re-issue requester 2 even though requester 0 is next in round-robin
    req_valid = 4'b0101;
    accept_en = 1'b1;
    tick();
    wait_valid(60, k);
    checks++; if (out_valid !== 1'b1 || grant_id !== 2'd2) begin errors++; $display("FAIL retry_grant got ov %b gid %0d exp 1/2", out_valid, grant_id); end
    checks++; if (out_data !== 40'h2222222222 || req_ready !== 4'b0100) begin errors++; $display("FAIL retry_data got %h rdy %b exp 2222222222/0100", out_data, req_ready); end
    req_valid = 4'b0001;
    step();
    checks++; if (err_reject !== 1'b1 || pkt_count !== 16'd1) begin errors++; $display("FAIL err_sticky got err %b cnt %0d exp 1/1", err_reject, pkt_count); end
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    checks++; if (err_reject !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err_reject); end
    // clear in the same cycle as a reject wins
    accept_en = 1'b0;
    tick();
    wait_valid(60, k);
    checks++; if (out_valid !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL rej2_grant got ov %b gid %0d exp 1/0", out_valid, grant_id); end
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    checks++; if (err_reject !== 1'b0) begin errors++; $display("FAIL clear_wins got %b exp 0", err_reject); end
    // retried requester withdrew: arbitrate normally from last_grant=2 -> 1
    req_valid = 4'b0010;
    accept_en = 1'b1;
    tick();
    wait_valid(60, k);
    checks++; if (out_valid !== 1'b1 || grant_id !== 2'd1 || req_ready !== 4'b0010) begin errors++; $display("FAIL drop_retry got ov %b gid %0d rdy %b exp 1/1/0010", out_valid, grant_id, req_ready); end
    req_valid = 4'b0000;
    step();
    checks++; if (pkt_count !== 16'd2) begin errors++; $display("FAIL drop_count got %0d exp 2", pkt_count); end
  endtask

  task automatic test_tick_restart();
    int first;
    int pulses;
    do_reset();
    d[0] = 40'h00DEADBEEF;
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    step();
    checks++; if (fsm_state !== 2'd2) begin errors++; $display("FAIL restart_wait got %0d exp 2", fsm_state); end
    req_valid = 4'b0001;
    tick();
    first = 0;
    pulses = 0;
    for (int i = 1; i <= 80; i++) begin
      frame_tick = (i == 20);
      step();
      if (out_valid) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    frame_tick = 1'b0;
    checks++; if (first !== 69) begin errors++; $display("FAIL restart_latency got %0d exp 69", first); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL restart_pulses got %0d exp 1", pulses); end
    req_valid = 4'b0000;
  endtask

  task automatic test_wrap();
    do_reset();
    d[3] = 40'h3300000033;
    force dut.pkt_count = 16'hFFFF;
    #1;
    release dut.pkt_count;
    @(negedge clk);
    req_valid = 4'b1000;
    step();
    checks++; if (out_valid !== 1'b1 || grant_id !== 2'd3) begin errors++; $display("FAIL wrap_issue got ov %b gid %0d exp 1/3", out_valid, grant_id); end
    req_valid = 4'b0000;
    step();
    checks++; if (pkt_count !== 16'h0000) begin errors++; $display("FAIL wrap_count got %h exp 0000", pkt_count); end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_reject();
    test_tick_restart();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
